logic_unit_pipe: RTL and testbench

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pkg.sv | 22 ++
 rtl/skid_buf.sv | 87 ++++++++
 rtl/logic_unit_pipe.sv | 83 ++++++++
 tb/tb_logic_unit_pipe.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic unit pipeline.
// Holds the op-select encodings and the skid-buffer state encoding.
package logic_unit_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
    localparam logic [OP_W-1:0] OP_PASS = 3'd6;
    localparam logic [OP_W-1:0] OP_NOTA = 3'd7;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/skid_buf.sv
// 2-entry skid buffer with registered ready/valid on both sides.
// Ports: clk, rst_n (sync, active-low), i_valid/i_data/o_ready upstream,
//        o_valid/o_data/i_out_ready downstream.
module skid_buf
    import logic_unit_pkg::*;
#(
    parameter int unsigned DW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    input  logic          i_out_ready
);

    skid_state_t   r_state;
    skid_state_t   w_state_nxt;
    logic [DW-1:0] r_main;
    logic [DW-1:0] r_skid;
    logic [DW-1:0] w_main_nxt;
    logic [DW-1:0] w_skid_nxt;
    logic          r_ready;
    logic          r_valid;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_valid & r_ready;
    assign w_pop  = r_valid & i_out_ready;

    // Next state and entry updates; r_main always holds the oldest beat.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            SKID_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = SKID_ONE;
                    w_main_nxt  = i_data;
                end
            end
            SKID_ONE: begin
                case ({w_push, w_pop})
                    2'b10: begin
                        w_state_nxt = SKID_FULL;
                        w_skid_nxt  = i_data;
                    end
                    2'b01: w_state_nxt = SKID_EMPTY;
                    2'b11: w_main_nxt  = i_data;
                    default: ;
                endcase
            end
            SKID_FULL: begin
                if (w_pop) begin
                    w_state_nxt = SKID_ONE;
                    w_main_nxt  = r_skid;
                end
            end
            default: w_state_nxt = SKID_EMPTY;
        endcase
    end

    // State/data registers; ready and valid are registered from next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SKID_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
            r_ready <= (w_state_nxt != SKID_FULL);
            r_valid <= (w_state_nxt != SKID_EMPTY);
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_main;

endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with one-cycle latency and a 2-entry output skid buffer.
// Ports: clk, rst_n (sync, active-low); a, b, op, in_valid, in_ready upstream;
//        y, y_all, y_any, out_valid, out_ready downstream; count = accepted
//        beats, saturating.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_all,
    output logic             y_any,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned DW = WIDTH + 2;

    logic [WIDTH-1:0] w_res;
    logic [DW-1:0]    w_in_data;
    logic [DW-1:0]    w_out_data;
    logic             w_in_ready;
    logic             w_accept;
    logic [CNT_W-1:0] r_count;

    // Operation decode.
    always_comb begin
        w_res = '0;
        case (op)
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_NAND: w_res = ~(a & b);
            OP_NOR:  w_res = ~(a | b);
            OP_XNOR: w_res = ~(a ^ b);
            OP_PASS: w_res = a;
            OP_NOTA: w_res = ~a;
            default: w_res = '0;
        endcase
    end

    // Reductions travel with the result so they always match the stored y.
    assign w_in_data = {w_res, &w_res, |w_res};
    assign w_accept  = in_valid & w_in_ready;

    skid_buf #(
        .DW (DW)
    ) u_skid_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (in_valid),
        .i_data      (w_in_data),
        .o_ready     (w_in_ready),
        .o_valid     (out_valid),
        .o_data      (w_out_data),
        .i_out_ready (out_ready)
    );

    // Saturating accepted-beat counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_accept && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign in_ready = w_in_ready;
    assign y        = w_out_data[DW-1:2];
    assign y_all    = w_out_data[1];
    assign y_any    = w_out_data[0];
    assign count    = r_count;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (WIDTH=8, CNT_W=4).
module tb_logic_unit_pipe;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] y;
    logic       y_all;
    logic       y_any;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] count;

    int n_pass;
    int n_total;

    logic [7:0] exp_ops [8];

    logic_unit_pipe #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .y_all     (y_all),
        .y_any     (y_any),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        op        = 3'd0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        else n_pass++;
        n_total++;
        if (y !== 8'h00) $display("FAIL reset_y got=%h exp=00", y);
        else n_pass++;
        n_total++;
        if ({y_all, y_any} !== 2'b00) $display("FAIL reset_red got=%b%b exp=00", y_all, y_any);
        else n_pass++;
        n_total++;
        if (count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", count);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        else n_pass++;
    endtask

    task automatic test_ops();
        do_reset();
        exp_ops = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0, 8'h0F};
        out_ready = 1'b1;
        a = 8'hF0;
        b = 8'hCC;
        for (int i = 0; i < 8; i++) begin
            op       = 3'(i);
            in_valid = 1'b1;
            step();
            n_total++;
            if (out_valid !== 1'b1 || y !== exp_ops[i])
                $display("FAIL op%0d got v=%b y=%h exp v=1 y=%h", i, out_valid, y, exp_ops[i]);
            else n_pass++;
        end
        in_valid = 1'b0;
        step();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL ops_drain got=%b exp=0", out_valid);
        else n_pass++;
        n_total++;
        if (count !== 4'd8) $display("FAIL ops_count got=%0d exp=8", count);
        else n_pass++;
    endtask

    task automatic test_reductions();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 8'hFF; b = 8'hFF; op = 3'd0;
        step();
        n_total++;
        if ({y, y_all, y_any} !== {8'hFF, 2'b11})
            $display("FAIL red_ones got y=%h all=%b any=%b exp y=ff all=1 any=1", y, y_all, y_any);
        else n_pass++;
        a = 8'h00; b = 8'h00; op = 3'd1;
        step();
        n_total++;
        if ({y, y_all, y_any} !== {8'h00, 2'b00})
            $display("FAIL red_zeros got y=%h all=%b any=%b exp y=00 all=0 any=0", y, y_all, y_any);
        else n_pass++;
        a = 8'h0F; op = 3'd6;
        step();
        n_total++;
        if ({y, y_all, y_any} !== {8'h0F, 2'b01})
            $display("FAIL red_mixed got y=%h all=%b any=%b exp y=0f all=0 any=1", y, y_all, y_any);
        else n_pass++;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 3'd6;
        b         = 8'h00;
        a = 8'hA0;
        step();
        n_total++;
        if (out_valid !== 1'b1 || y !== 8'hA0 || in_ready !== 1'b1)
            $display("FAIL bp_first got v=%b y=%h rdy=%b exp v=1 y=a0 rdy=1", out_valid, y, in_ready);
        else n_pass++;
        a = 8'hA1;
        step();
        n_total++;
        if (in_ready !== 1'b0 || y !== 8'hA0)
            $display("FAIL bp_full got rdy=%b y=%h exp rdy=0 y=a0", in_ready, y);
        else n_pass++;
        a = 8'hA2;
        step();
        step();
        n_total++;
        if (in_ready !== 1'b0 || y !== 8'hA0 || count !== 4'd2)
            $display("FAIL bp_hold got rdy=%b y=%h cnt=%0d exp rdy=0 y=a0 cnt=2", in_ready, y, count);
        else n_pass++;
        out_ready = 1'b1;
        step();
        n_total++;
        if (out_valid !== 1'b1 || y !== 8'hA1 || in_ready !== 1'b1 || count !== 4'd2)
            $display("FAIL bp_a1 got v=%b y=%h rdy=%b cnt=%0d exp v=1 y=a1 rdy=1 cnt=2",
                     out_valid, y, in_ready, count);
        else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b1 || y !== 8'hA2 || count !== 4'd3)
            $display("FAIL bp_a2 got v=%b y=%h cnt=%0d exp v=1 y=a2 cnt=3", out_valid, y, count);
        else n_pass++;
        in_valid = 1'b0;
        step();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int errs;
        errs = 0;
        do_reset();
        out_ready = 1'b1;
        b  = 8'h55;
        op = 3'd2;
        for (int i = 0; i < 10; i++) begin
            a        = 8'(i);
            in_valid = 1'b1;
            step();
            if (out_valid !== 1'b1 || y !== (8'(i) ^ 8'h55) || in_ready !== 1'b1) begin
                $display("FAIL b2b_beat%0d got v=%b y=%h rdy=%b exp v=1 y=%h rdy=1",
                         i, out_valid, y, in_ready, 8'(i) ^ 8'h55);
                errs++;
            end
        end
        n_total++;
        if (errs == 0) n_pass++;
        in_valid = 1'b0;
        step();
        n_total++;
        if (count !== 4'd10) $display("FAIL b2b_count got=%0d exp=10", count);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        op = 3'd6;
        for (int i = 0; i < 20; i++) begin
            a        = 8'(i);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        n_total++;
        if (y !== 8'd19) $display("FAIL sat_last_y got=%h exp=13", y);
        else n_pass++;
        step();
        n_total++;
        if (count !== 4'd15) $display("FAIL sat_count got=%0d exp=15", count);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int errs;
        errs = 0;
        do_reset();
        out_ready = 1'b0;
        op        = 3'd6;
        in_valid  = 1'b1;
        a = 8'h11;
        step();
        a = 8'h22;
        step();
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL rm_full got rdy=%b exp=0", in_ready);
        else n_pass++;
        // Beat offered during reset must be dropped.
        rst_n = 1'b0;
        a     = 8'h33;
        step();
        n_total++;
        if (out_valid !== 1'b0 || count !== 4'd0 || in_ready !== 1'b1 || y !== 8'h00)
            $display("FAIL rm_after got v=%b cnt=%0d rdy=%b y=%h exp v=0 cnt=0 rdy=1 y=00",
                     out_valid, count, in_ready, y);
        else n_pass++;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid !== 1'b0) begin
                $display("FAIL rm_stale cycle%0d got v=%b y=%h exp v=0", i, out_valid, y);
                errs++;
            end
        end
        n_total++;
        if (errs == 0) n_pass++;
        n_total++;
        if (count !== 4'd0) $display("FAIL rm_count got=%0d exp=0", count);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a  = 8'h00;
        b  = 8'h00;
        op = 3'd0;
        test_reset();
        test_ops();
        test_reductions();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
